// File: rtl/turbosound_mixer.sv
// turbosound_mixer
//
// Stereo mixer that follows the dual-PSG TurboSound block. On each PSG clock
// enable it snapshots the six channel levels (A/B/C of chip 1 and chip 2),
// the panning mode and the chip-2 mute. It then accumulates them one channel
// per clock into 11-bit left/right sums, and presents the result with a
// one-cycle strobe.
//
// Ports:
//   clock  in   system clock, all state changes on the rising edge
//   reset  in   synchronous, active-high
//   ce     in   sample enable (the PSG clock enable)
//   mode   in   [1:0] panning: 00 ABC, 01 ACB, 10/11 mono
//   mute2  in   1 = chip-2 channels contribute zero
//   a1..c2 in   [7:0] channel levels, unsigned
//   left   out  [10:0] mixed left sample, held between strobes
//   right  out  [10:0] mixed right sample, held between strobes
//   valid  out  one-cycle strobe, left/right were updated this cycle
//
// Handshake: there is no back-pressure. A ce pulse requests one sample. If
// the sequencer is busy, one request is remembered and the rest are dropped.
// Each completed sample produces exactly one valid cycle.
//
// The current FSM state is available as the internal signal 'state'.

module turbosound_mixer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [1:0]  mode,
  input  logic        mute2,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [7:0]  c1,
  input  logic [7:0]  a2,
  input  logic [7:0]  b2,
  input  logic [7:0]  c2,
  output logic [10:0] left,
  output logic [10:0] right,
  output logic        valid
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5,
    S5   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        pending;
  logic        start;

  logic [7:0]  snap_a1, snap_b1, snap_c1, snap_a2, snap_b2, snap_c2;
  logic [1:0]  snap_mode;
  logic        snap_mute2;
  logic [10:0] acc_left;
  logic [10:0] acc_right;

  // Channel selected by the current accumulate state, with its A/B/C slot.
  logic [7:0]  cur_level;
  logic [1:0]  cur_slot;     // 0 = A, 1 = B, 2 = C
  logic        cur_chip2;
  logic        accumulating;
  logic [1:0]  w_left;
  logic [1:0]  w_right;
  logic [7:0]  eff_level;
  logic [10:0] add_left;
  logic [10:0] add_right;

  // Next-state logic. A new snapshot starts from IDLE on ce, or straight out
  // of DONE when a request is pending or arrives on that same edge.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (ce) begin
          start      = 1'b1;
          next_state = S0;
        end
      end
      S0:   next_state = S1;
      S1:   next_state = S2;
      S2:   next_state = S3;
      S3:   next_state = S4;
      S4:   next_state = S5;
      S5:   next_state = DONE;
      DONE: begin
        if (pending || ce) begin
          start      = 1'b1;
          next_state = S0;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Channel mux: S0..S5 walk a1, b1, c1, a2, b2, c2.
  always_comb begin
    cur_level    = 8'd0;
    cur_slot     = 2'd0;
    cur_chip2    = 1'b0;
    accumulating = 1'b1;
    case (state)
      S0: begin cur_level = snap_a1; cur_slot = 2'd0; end
      S1: begin cur_level = snap_b1; cur_slot = 2'd1; end
      S2: begin cur_level = snap_c1; cur_slot = 2'd2; end
      S3: begin cur_level = snap_a2; cur_slot = 2'd0; cur_chip2 = 1'b1; end
      S4: begin cur_level = snap_b2; cur_slot = 2'd1; cur_chip2 = 1'b1; end
      S5: begin cur_level = snap_c2; cur_slot = 2'd2; cur_chip2 = 1'b1; end
      default: accumulating = 1'b0;
    endcase
  end

  // Pan weights per slot. ACB swaps the B and C positions of ABC. Mode 11
  // is treated as mono.
  always_comb begin
    w_left  = 2'd1;
    w_right = 2'd1;
    if (snap_mode == 2'b00) begin
      case (cur_slot)
        2'd0:    begin w_left = 2'd2; w_right = 2'd0; end
        2'd1:    begin w_left = 2'd1; w_right = 2'd1; end
        default: begin w_left = 2'd0; w_right = 2'd2; end
      endcase
    end else if (snap_mode == 2'b01) begin
      case (cur_slot)
        2'd0:    begin w_left = 2'd2; w_right = 2'd0; end
        2'd1:    begin w_left = 2'd0; w_right = 2'd2; end
        default: begin w_left = 2'd1; w_right = 2'd1; end
      endcase
    end
  end

  // A muted chip 2 still spends its three cycles; it just adds zero.
  assign eff_level = (cur_chip2 && snap_mute2) ? 8'd0 : cur_level;

  always_comb begin
    add_left  = 11'd0;
    add_right = 11'd0;
    case (w_left)
      2'd1:    add_left = {3'd0, eff_level};
      2'd2:    add_left = {2'd0, eff_level, 1'b0};
      default: add_left = 11'd0;
    endcase
    case (w_right)
      2'd1:    add_right = {3'd0, eff_level};
      2'd2:    add_right = {2'd0, eff_level, 1'b0};
      default: add_right = 11'd0;
    endcase
  end

  // Worst case is 6*255 weighted to 1530, so 11 bits never overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      snap_a1    <= 8'd0;
      snap_b1    <= 8'd0;
      snap_c1    <= 8'd0;
      snap_a2    <= 8'd0;
      snap_b2    <= 8'd0;
      snap_c2    <= 8'd0;
      snap_mode  <= 2'd0;
      snap_mute2 <= 1'b0;
      acc_left   <= 11'd0;
      acc_right  <= 11'd0;
      left       <= 11'd0;
      right      <= 11'd0;
      valid      <= 1'b0;
    end else begin
      state <= next_state;
      valid <= 1'b0;

      if (start) begin
        snap_a1    <= a1;
        snap_b1    <= b1;
        snap_c1    <= c1;
        snap_a2    <= a2;
        snap_b2    <= b2;
        snap_c2    <= c2;
        snap_mode  <= mode;
        snap_mute2 <= mute2;
        acc_left   <= 11'd0;
        acc_right  <= 11'd0;
      end else if (accumulating) begin
        acc_left  <= acc_left + add_left;
        acc_right <= acc_right + add_right;
      end

      if (state == DONE) begin
        left  <= acc_left;
        right <= acc_right;
        valid <= 1'b1;
      end

      // DONE always consumes the held request (and any ce on that edge).
      // While busy, a single request is remembered.
      if (state == DONE) begin
        pending <= 1'b0;
      end else if (state != IDLE && ce) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_turbosound_mixer.sv
// tb_turbosound_mixer
//
// Bench for turbosound_mixer: reset checks, a table of directed vectors,
// hand-written pending / reset-abort / snapshot sequences, and randomized
// samples compared against a behavioural pan/sum model.

module tb_turbosound_mixer;

  logic        clock;
  logic        reset;
  logic        ce;
  logic [1:0]  mode;
  logic        mute2;
  logic [7:0]  a1, b1, c1, a2, b2, c2;
  logic [10:0] left;
  logic [10:0] right;
  logic        valid;

  int passed;
  int total;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic       mute2;
    logic [7:0] a1, b1, c1, a2, b2, c2;
    int         exp_l;
    int         exp_r;
  } vec_t;

  vec_t vecs[$];

  turbosound_mixer dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .mode  (mode),
    .mute2 (mute2),
    .a1    (a1),
    .b1    (b1),
    .c1    (c1),
    .a2    (a2),
    .b2    (b2),
    .c2    (c2),
    .left  (left),
    .right (right),
    .valid (valid)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checker
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: each channel level times its pan weight per side,
  // summed over both chips.
  function automatic void model(input vec_t v, output int l, output int r);
    int lvl[6];
    int wl[3];
    int wr[3];
    l = 0;
    r = 0;
    lvl = '{int'(v.a1), int'(v.b1), int'(v.c1), int'(v.a2), int'(v.b2), int'(v.c2)};
    case (v.mode)
      2'b00: begin wl = '{2, 1, 0}; wr = '{0, 1, 2}; end
      2'b01: begin wl = '{2, 0, 1}; wr = '{0, 2, 1}; end
      default: begin wl = '{1, 1, 1}; wr = '{1, 1, 1}; end
    endcase
    for (int i = 0; i < 6; i++) begin
      if (!(i >= 3 && v.mute2)) begin
        l += wl[i % 3] * lvl[i];
        r += wr[i % 3] * lvl[i];
      end
    end
  endfunction

  function automatic vec_t mk(input string name, input logic [1:0] m,
                              input logic mu, input int x1, input int y1,
                              input int z1, input int x2, input int y2,
                              input int z2, input int el, input int er);
    vec_t v;
    v.name = name; v.mode = m; v.mute2 = mu;
    v.a1 = 8'(x1); v.b1 = 8'(y1); v.c1 = 8'(z1);
    v.a2 = 8'(x2); v.b2 = 8'(y2); v.c2 = 8'(z2);
    v.exp_l = el; v.exp_r = er;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.name = "rand";
    v.mode = 2'($urandom_range(0, 3));
    v.mute2 = 1'($urandom_range(0, 1));
    v.a1 = 8'($urandom); v.b1 = 8'($urandom); v.c1 = 8'($urandom);
    v.a2 = 8'($urandom); v.b2 = 8'($urandom); v.c2 = 8'($urandom);
    v.exp_l = 0; v.exp_r = 0;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    mode = v.mode; mute2 = v.mute2;
    a1 = v.a1; b1 = v.b1; c1 = v.c1;
    a2 = v.a2; b2 = v.b2; c2 = v.c2;
  endtask

  // One ce pulse, then wait (bounded) for the strobe and check it. With
  // scramble set, every input changes right after the ce edge.
  task automatic run_sample(input vec_t v, input bit scramble);
    int lat;
    lat = -1;
    @(negedge clock);
    drive(v);
    ce = 1'b1;
    @(negedge clock);
    ce = 1'b0;
    if (scramble) drive(rand_vec());
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (valid) begin
        lat = k;
        break;
      end
    end
    check({v.name, " latency"}, lat, 7);
    check({v.name, " left"}, int'(left), v.exp_l);
    check({v.name, " right"}, int'(right), v.exp_r);
    @(negedge clock);
    check({v.name, " valid width"}, int'(valid), 0);
    check({v.name, " left hold"}, int'(left), v.exp_l);
  endtask

  vec_t vx;
  vec_t vy;
  int   vk_q[$];
  int   vl_q[$];
  int   vcount;
  int   el, er;

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    ce     = 1'b0;
    drive(rand_vec());

    // Reset with random inputs and ce toggling: nothing may start.
    repeat (2) begin
      @(negedge clock);
      drive(rand_vec());
      ce = ~ce;
    end
    @(negedge clock);
    check("reset left", int'(left), 0);
    check("reset right", int'(right), 0);
    check("reset valid", int'(valid), 0);
    reset = 1'b0;
    ce    = 1'b0;
    vcount = 0;
    repeat (10) begin
      @(negedge clock);
      if (valid) vcount++;
    end
    check("no sample from ce under reset", vcount, 0);

    // Directed table
    vecs.push_back(mk("abc",        2'b00, 1'b0, 100, 50, 20, 0, 0, 0, 250, 90));
    vecs.push_back(mk("acb",        2'b01, 1'b0, 100, 50, 20, 0, 0, 0, 220, 120));
    vecs.push_back(mk("mono",       2'b10, 1'b0, 100, 50, 20, 0, 0, 0, 170, 170));
    vecs.push_back(mk("max",        2'b00, 1'b0, 255, 255, 255, 255, 255, 255, 1530, 1530));
    vecs.push_back(mk("max mute",   2'b00, 1'b1, 255, 255, 255, 255, 255, 255, 765, 765));
    vecs.push_back(mk("mode3 mono", 2'b11, 1'b0, 1, 2, 3, 10, 20, 30, 66, 66));
    vecs.push_back(mk("chip2 abc",  2'b00, 1'b0, 0, 0, 0, 10, 20, 30, 40, 80));
    vecs.push_back(mk("acb mute",   2'b01, 1'b1, 7, 9, 11, 255, 255, 255, 25, 29));
    foreach (vecs[i]) run_sample(vecs[i], 1'b0);

    // Snapshot isolation: a1 and everything else change one clock after ce.
    run_sample(mk("snapshot", 2'b00, 1'b1, 255, 255, 255, 255, 255, 255, 765, 765), 1'b1);

    // Pending: ce at E0, E3, E5. The second sample snapshots at DONE.
    vx = mk("px", 2'b00, 1'b0, 100, 50, 20, 0, 0, 0, 250, 90);
    vy = mk("py", 2'b10, 1'b0, 1, 2, 3, 4, 5, 6, 21, 21);
    @(negedge clock);
    drive(vx);
    ce = 1'b1;
    @(negedge clock);
    ce = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (valid) begin
        vk_q.push_back(k);
        vl_q.push_back(int'(left));
        vl_q.push_back(int'(right));
      end
      ce = (k == 2 || k == 4);
      if (k == 5) drive(vy);
    end
    ce = 1'b0;
    check("pending strobe count", vk_q.size(), 2);
    if (vk_q.size() == 2) begin
      check("pending first at", vk_q[0], 7);
      check("pending second at", vk_q[1], 14);
      check("pending first left", vl_q[0], 250);
      check("pending first right", vl_q[1], 90);
      check("pending second left", vl_q[2], 21);
      check("pending second right", vl_q[3], 21);
    end

    // Reset mid-sequence, sampled at E4.
    @(negedge clock);
    drive(vx);
    ce = 1'b1;
    @(negedge clock);
    ce = 1'b0;
    vcount = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (valid) vcount++;
      reset = (k == 3);
    end
    reset = 1'b0;
    check("abort no valid", vcount, 0);
    check("abort left", int'(left), 0);
    check("abort right", int'(right), 0);
    run_sample(mk("after abort", 2'b01, 1'b0, 100, 50, 20, 0, 0, 0, 220, 120), 1'b0);

    // Randomized samples against the model
    for (int n = 0; n < 40; n++) begin
      vx = rand_vec();
      model(vx, el, er);
      vx.exp_l = el;
      vx.exp_r = er;
      run_sample(vx, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
